// File: rtl/sim_run_ctrl.sv
// Run controller for a DUT under test: holds the DUT in reset for a fixed
// window after start, then counts run cycles until finish_req (PASS) or a watchdog (TIMEOUT).
module sim_run_ctrl #(
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             finish_req,
  output logic             dut_reset,
  output logic             run,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic [1:0]       status
);

  localparam int RST_W = ($clog2(RESET_CYCLES + 1) < 1) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("sim_run_ctrl: RESET_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_min
    $error("sim_run_ctrl: TIMEOUT_CYCLES must be >= 1");
  end
  if ((CNT_W < 32) && (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_timeout_max
    $error("sim_run_ctrl: TIMEOUT_CYCLES must be < 2**CNT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_RUN     = 3'd2,
    S_PASS    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [RST_W-1:0] rst_cnt, rst_cnt_n;
  logic [CNT_W-1:0] cnt_n;
  logic             dut_reset_n, run_n, done_n;
  logic [1:0]       status_n;

  // start is a level: it is acted on only in IDLE/PASS/TIMEOUT, so holding
  // it high restarts immediately after every end of run.
  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    cnt_n     = cycle_count;
    case (state)
      S_IDLE, S_PASS, S_TIMEOUT: begin
        if (start) begin
          state_n   = S_RESET;
          rst_cnt_n = '0;
        end
      end
      S_RESET: begin
        // The entry edge leaves rst_cnt at 0, so RUN is reached
        // RESET_CYCLES+1 edges after the edge that sampled start.
        if (rst_cnt == RST_LAST) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          rst_cnt_n = rst_cnt + RST_W'(1);
        end
      end
      S_RUN: begin
        if (finish_req) begin
          state_n = S_PASS;
        end else if (cycle_count == CNT_LAST) begin
          state_n = S_TIMEOUT;
        end else begin
          cnt_n = cycle_count + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered with it.
    dut_reset_n = (state_n != S_RUN);
    run_n       = (state_n == S_RUN);
    done_n      = (state_n == S_PASS) || (state_n == S_TIMEOUT);
    status_n    = (state_n == S_PASS)    ? 2'd1 :
                  (state_n == S_TIMEOUT) ? 2'd2 : 2'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      cycle_count <= '0;
      dut_reset   <= 1'b1;
      run         <= 1'b0;
      done        <= 1'b0;
      status      <= 2'd0;
    end else begin
      state       <= state_n;
      rst_cnt     <= rst_cnt_n;
      cycle_count <= cnt_n;
      dut_reset   <= dut_reset_n;
      run         <= run_n;
      done        <= done_n;
      status      <= status_n;
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: three instances (default, short watchdog, minimal
// windows) driven by a vector table plus hand-written multi-cycle sequences.
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, fin_a, start_b, fin_b, start_c, fin_c;
  logic        dr_a, run_a, done_a, dr_b, run_b, done_b, dr_c, run_c, done_c;
  logic [1:0]  st_a, st_b, st_c;
  logic [31:0] cc_a, cc_b, cc_c;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        start;
    logic        fin;
    logic        dr;
    logic        run;
    logic        done;
    logic [1:0]  st;
    logic [31:0] cc;
  } vec_t;

  vec_t        vecs[$];
  logic [36:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  sim_run_ctrl #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(1000), .CNT_W(32)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .finish_req(fin_a),
    .dut_reset(dr_a), .run(run_a), .cycle_count(cc_a), .done(done_a), .status(st_a)
  );

  sim_run_ctrl #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(10), .CNT_W(32)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .finish_req(fin_b),
    .dut_reset(dr_b), .run(run_b), .cycle_count(cc_b), .done(done_b), .status(st_b)
  );

  sim_run_ctrl #(.RESET_CYCLES(1), .TIMEOUT_CYCLES(1), .CNT_W(32)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .finish_req(fin_c),
    .dut_reset(dr_c), .run(run_c), .cycle_count(cc_c), .done(done_c), .status(st_c)
  );

  // driver / helper tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [36:0] pack(input logic dr, input logic rn, input logic dn,
                                       input logic [1:0] st, input logic [31:0] cc);
    return {dr, rn, dn, st, cc};
  endfunction

  function automatic logic [36:0] obs_a();
    return {dr_a, run_a, done_a, st_a, cc_a};
  endfunction

  function automatic logic [36:0] obs_b();
    return {dr_b, run_b, done_b, st_b, cc_b};
  endfunction

  function automatic logic [36:0] obs_c();
    return {dr_c, run_c, done_c, st_c, cc_c};
  endfunction

  function automatic void add(input logic s, input logic f, input logic dr, input logic rn,
                              input logic dn, input logic [1:0] st, input logic [31:0] cc);
    vec_t v;
    v.start = s; v.fin = f; v.dr = dr; v.run = rn; v.done = dn; v.st = st; v.cc = cc;
    vecs.push_back(v);
  endfunction

  // scoreboard compare; got/exp are {dut_reset, run, done, status, cycle_count}
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic wait_run_a();
    for (int i = 0; i < 20 && !run_a; i++) step();
    check("a_run_wait", 64'(run_a), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    start_a = 0; fin_a = 0; start_b = 0; fin_b = 0; start_c = 0; fin_c = 0;

    // reset values after 5 cycles of reset_n low
    repeat (5) step();
    check("reset_a", obs_a(), pack(1, 0, 0, 2'd0, 0));
    check("reset_b", obs_b(), pack(1, 0, 0, 2'd0, 0));
    check("reset_c", obs_c(), pack(1, 0, 0, 2'd0, 0));
    reset_n = 1'b1;
    step();

    // vector table on dut_b (RESET_CYCLES=4, TIMEOUT_CYCLES=10)
    add(1, 0, 1, 0, 0, 2'd0, 0);                      // start sampled -> RESET
    for (int k = 0; k < 4; k++) add(0, 0, 1, 0, 0, 2'd0, 0);
    add(0, 0, 0, 1, 0, 2'd0, 0);                      // RUN entry
    add(0, 0, 0, 1, 0, 2'd0, 1);
    add(1, 0, 0, 1, 0, 2'd0, 2);                      // start ignored in RUN
    add(0, 1, 1, 0, 1, 2'd1, 2);                      // PASS, no increment
    add(0, 1, 1, 0, 1, 2'd1, 2);                      // finish ignored in PASS
    add(1, 0, 1, 0, 0, 2'd0, 2);                      // restart, count holds
    for (int k = 0; k < 4; k++) add(0, 1, 1, 0, 0, 2'd0, 2);
    add(0, 0, 0, 1, 0, 2'd0, 0);
    add(0, 1, 1, 0, 1, 2'd1, 0);                      // finish on first RUN cycle
    for (int k = 0; k < 5; k++) add(1, 0, 1, 0, 0, 2'd0, 0);
    add(1, 0, 0, 1, 0, 2'd0, 0);                      // start held through RUN
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 1, 0, 2'd0, k);
    add(0, 0, 1, 0, 1, 2'd2, 9);                      // TIMEOUT after 10 RUN cycles
    add(1, 0, 1, 0, 0, 2'd0, 9);                      // level start restarts

    foreach (vecs[i]) begin
      start_b = vecs[i].start;
      fin_b   = vecs[i].fin;
      exp_q.push_back(pack(vecs[i].dr, vecs[i].run, vecs[i].done, vecs[i].st, vecs[i].cc));
      step();
      check($sformatf("vec%0d", i), obs_b(), exp_q.pop_front());
    end
    start_b = 0;

    // tie: finish_req on the cycle the watchdog expires -> PASS
    for (int i = 0; i < 40 && !(run_b && cc_b == 32'd9); i++) step();
    check("tie_reach", obs_b(), pack(0, 1, 0, 2'd0, 9));
    fin_b = 1;
    step();
    check("tie_pass", obs_b(), pack(1, 0, 1, 2'd1, 9));
    fin_b = 0;

    // normal run on dut_a: finish after 100 RUN cycles
    start_a = 1;
    step();
    start_a = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("a_rst_win%0d", k), obs_a(), pack(1, 0, 0, 2'd0, 0));
    end
    step();
    check("a_run_rise", obs_a(), pack(0, 1, 0, 2'd0, 0));
    repeat (100) step();
    check("a_run100", obs_a(), pack(0, 1, 0, 2'd0, 100));
    fin_a = 1;
    step();
    fin_a = 0;
    check("a_pass", obs_a(), pack(1, 0, 1, 2'd1, 100));
    repeat (3) step();
    check("a_pass_hold", obs_a(), pack(1, 0, 1, 2'd1, 100));

    // restart from PASS, with start pulses in RESET and RUN ignored
    start_a = 1;
    step();
    check("a_restart", obs_a(), pack(1, 0, 0, 2'd0, 100));
    step();
    check("a_start_in_reset", obs_a(), pack(1, 0, 0, 2'd0, 100));
    start_a = 0;
    repeat (3) step();
    check("a_rst_end", obs_a(), pack(1, 0, 0, 2'd0, 100));
    step();
    check("a_run2", obs_a(), pack(0, 1, 0, 2'd0, 0));
    start_a = 1;
    step();
    start_a = 0;
    check("a_start_in_run", obs_a(), pack(0, 1, 0, 2'd0, 1));
    step();
    fin_a = 1;
    step();
    fin_a = 0;
    check("a_pass2", obs_a(), pack(1, 0, 1, 2'd1, 2));

    // abort: asynchronous reset mid-RUN at cycle_count=30
    start_a = 1;
    step();
    start_a = 0;
    wait_run_a();
    repeat (30) step();
    check("a_at30", obs_a(), pack(0, 1, 0, 2'd0, 30));
    #2;
    reset_n = 1'b0;
    #1;
    check("a_async_rst", obs_a(), pack(1, 0, 0, 2'd0, 0));
    step();
    reset_n = 1'b1;
    start_a = 1;
    step();
    start_a = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("a_abort_win%0d", k), obs_a(), pack(1, 0, 0, 2'd0, 0));
    end
    step();
    check("a_abort_run", obs_a(), pack(0, 1, 0, 2'd0, 0));
    step();
    check("a_abort_cnt1", obs_a(), pack(0, 1, 0, 2'd0, 1));

    // dut_c: RESET_CYCLES=1, TIMEOUT_CYCLES=1
    fin_c = 1;
    step();
    check("c_fin_idle", obs_c(), pack(1, 0, 0, 2'd0, 0));
    fin_c = 0;
    start_c = 1;
    step();
    start_c = 0;
    check("c_reset0", obs_c(), pack(1, 0, 0, 2'd0, 0));
    step();
    check("c_reset1", obs_c(), pack(1, 0, 0, 2'd0, 0));
    step();
    check("c_run", obs_c(), pack(0, 1, 0, 2'd0, 0));
    step();
    check("c_timeout", obs_c(), pack(1, 0, 1, 2'd2, 0));
    start_c = 1;
    step();
    start_c = 0;
    check("c_restart", obs_c(), pack(1, 0, 0, 2'd0, 0));
    repeat (2) step();
    check("c_run2", obs_c(), pack(0, 1, 0, 2'd0, 0));
    fin_c = 1;
    step();
    fin_c = 0;
    check("c_pass", obs_c(), pack(1, 0, 1, 2'd1, 0));

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
